// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM states,
// datapath mux selects and the control bundle driven into the datapath.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control decode. Moore outputs except IRWrite/PCWrite
// in FETCH, which follow mem_ready so the IR and PC load only on a completed read.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMMSH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.branch    = 1'b1;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and stalls in FETCH, MEMRD and MEMWR until the memory reports ready.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4; load IR/PC on mem_ready
// DECODE | read regs, precompute branch target, dispatch on Op
// MEMADR | compute lw/sw effective address
// MEMRD  | data read, wait for mem_ready
// MEMWB  | write MDR to rt
// MEMWR  | data write, wait for mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALUOut to rd
// BRANCH | beq compare, conditional PC load
// ADDIEX | addi ALU operation
// ADDIWB | write ALUOut to rt
// JUMP   | load jump target into PC
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ENABLE_ADDI = 1,
    parameter int ENABLE_J    = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            mem_ready,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            Branch,
    output logic [1:0]      PCSrc,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            illegal_op,
    output logic [3:0]      state_dbg
);

    state_t state_q, state_d;
    logic   illegal_d;
    ctrl_t  ctrl_raw, ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                // Default branch also catches an X opcode, so it lands safely in FETCH
                case (Op)
                    OP_W'(OP_RTYPE):        state_d = S_EXEC;
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):           state_d = S_MEMADR;
                    OP_W'(OP_BEQ):          state_d = S_BRANCH;
                    OP_W'(OP_ADDI): begin
                        if (ENABLE_ADDI != 0) state_d = S_ADDIEX;
                        else                  illegal_d = 1'b1;
                    end
                    OP_W'(OP_J): begin
                        if (ENABLE_J != 0) state_d = S_JUMP;
                        else               illegal_d = 1'b1;
                    end
                    default:                illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (Op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    // Gate with reset so a reset landing mid-instruction never leaks a write strobe
    assign ctrl       = reset ? '0 : ctrl_raw;
    assign illegal_op = illegal_d & ~reset;
    assign state_dbg  = reset ? 4'd0 : state_q;

    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign PCWrite  = ctrl.pc_write;
    assign Branch   = ctrl.branch;
    assign PCSrc    = ctrl.pc_src;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: two instances (all opcodes enabled, addi/j disabled)
// checked each cycle against an instruction-level model, plus literal state traces.
module tb_multicycle_main_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       mr  [2];
    logic [5:0] op  [2];

    logic       iord [2], mrd [2], mwr [2], irw [2], pcw [2], br [2];
    logic [1:0] pcsrc [2], asb [2], aop [2];
    logic       asa [2], rd [2], m2r [2], rw [2], ill [2];
    logic [3:0] dbg [2];

    multicycle_main_control #(.OP_W(6), .ENABLE_ADDI(1), .ENABLE_J(1)) dut0 (
        .clk(clk), .reset(rst[0]), .Op(op[0]), .mem_ready(mr[0]),
        .IorD(iord[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]), .IRWrite(irw[0]),
        .PCWrite(pcw[0]), .Branch(br[0]), .PCSrc(pcsrc[0]), .ALUSrcA(asa[0]),
        .ALUSrcB(asb[0]), .ALUOp(aop[0]), .RegDst(rd[0]), .MemtoReg(m2r[0]),
        .RegWrite(rw[0]), .illegal_op(ill[0]), .state_dbg(dbg[0])
    );

    multicycle_main_control #(.OP_W(6), .ENABLE_ADDI(0), .ENABLE_J(0)) dut1 (
        .clk(clk), .reset(rst[1]), .Op(op[1]), .mem_ready(mr[1]),
        .IorD(iord[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]), .IRWrite(irw[1]),
        .PCWrite(pcw[1]), .Branch(br[1]), .PCSrc(pcsrc[1]), .ALUSrcA(asa[1]),
        .ALUSrcB(asb[1]), .ALUOp(aop[1]), .RegDst(rd[1]), .MemtoReg(m2r[1]),
        .RegWrite(rw[1]), .illegal_op(ill[1]), .state_dbg(dbg[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per-state expected control vector, and per-instruction list of states after DECODE
    logic [15:0] tbl [16];
    logic [3:0]  m_st [2];
    logic [15:0] m_path [2];

    function automatic logic [15:0] mk(input logic io, mrd_, mwr_, irw_, pcw_, br_,
                                       input logic [1:0] pcs, input logic a,
                                       input logic [1:0] b, input logic [1:0] ao,
                                       input logic rdst, m2r_, rw_);
        return {io, mrd_, mwr_, irw_, pcw_, br_, pcs, a, b, ao, rdst, m2r_, rw_};
    endfunction

    function automatic logic [15:0] dut_vec(input int k);
        return {iord[k], mrd[k], mwr[k], irw[k], pcw[k], br[k], pcsrc[k], asa[k],
                asb[k], aop[k], rd[k], m2r[k], rw[k]};
    endfunction

    // States visited after DECODE, one nibble each, earliest in the low nibble; 0 = illegal
    function automatic logic [15:0] plan(input logic [5:0] o, input int k);
        case (o)
            6'b000000: return 16'h0076;
            6'b100011: return 16'h0432;
            6'b101011: return 16'h0052;
            6'b000100: return 16'h0008;
            6'b001000: return (k == 0) ? 16'h00A9 : 16'h0000;
            6'b000010: return (k == 0) ? 16'h000B : 16'h0000;
            default:   return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_and_advance();
        logic [15:0] ev, nxt;
        logic        ei;
        logic [3:0]  es;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                ev = '0; ei = 1'b0; es = 4'd0;
            end else begin
                ev = tbl[m_st[k]];
                if (m_st[k] == 4'd0) begin
                    ev[12] = mr[k];
                    ev[11] = mr[k];
                end
                ei = (m_st[k] == 4'd1) && (plan(op[k], k) == 16'h0);
                es = m_st[k];
            end
            chk($sformatf("ctrl%0d_st%0d", k, m_st[k]), 64'(dut_vec(k)), 64'(ev));
            chk($sformatf("illegal%0d_st%0d", k, m_st[k]), 64'(ill[k]), 64'(ei));
            chk($sformatf("state_dbg%0d", k), 64'(dbg[k]), 64'(es));
            if (rst[k]) begin
                m_st[k] = 4'd0; m_path[k] = '0;
            end else if (m_st[k] == 4'd0) begin
                m_st[k] = mr[k] ? 4'd1 : 4'd0;
            end else if (m_st[k] == 4'd1) begin
                nxt = plan(op[k], k);
                m_st[k] = nxt[3:0];
                m_path[k] = nxt >> 4;
            end else if (!((m_st[k] == 4'd3 || m_st[k] == 4'd5) && !mr[k])) begin
                m_st[k] = m_path[k][3:0];
                m_path[k] = m_path[k] >> 4;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string name, input int k, input logic [5:0] opc, input int n,
                           input logic [15:0] pat, input logic [63:0] exp_st,
                           input logic [15:0] exp_ill);
        logic [63:0] got_st;
        logic [15:0] got_ill;
        got_st = '0; got_ill = '0;
        for (int i = 0; i < n; i++) begin
            op[k] = opc;
            mr[k] = pat[i];
            @(negedge clk);
            check_and_advance();
            got_st[i*4 +: 4] = dbg[k];
            got_ill[i] = ill[k];
            @(posedge clk);
            #1;
        end
        mr[k] = 1'b0;
        chk({name, "_states"}, got_st, exp_st);
        chk({name, "_illegal"}, 64'(got_ill), 64'(exp_ill));
    endtask

    initial begin
        tbl[0]  = mk(0,1,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0);
        tbl[3]  = mk(1,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0);
        tbl[4]  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1);
        tbl[5]  = mk(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0);
        tbl[6]  = mk(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0);
        tbl[7]  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1);
        tbl[8]  = mk(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0);
        tbl[9]  = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0);
        tbl[10] = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1);
        tbl[11] = mk(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0);
        for (int s = 12; s < 16; s++) tbl[s] = '0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; mr[k] = 1'b1; op[k] = 6'b100011;
            m_st[k] = 4'd0; m_path[k] = '0;
        end
        @(posedge clk);
        #1;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_and_advance();
            chk("reset_ctrl", 64'(dut_vec(0)), 64'h0);
            chk("reset_state", 64'(dbg[0]), 64'h0);
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; mr[k] = 1'b0; op[k] = 6'b0;
        end
        @(negedge clk);
        check_and_advance();
        chk("fetch_memread", 64'(mrd[0]), 64'h1);
        chk("fetch_alusrcb", 64'(asb[0]), 64'h1);
        chk("fetch_irwrite_stalled", 64'(irw[0]), 64'h0);
        @(posedge clk);
        #1;

        run_seq("rtype", 0, 6'b000000, 5, 16'b01111, 64'h07610, 16'h0);
        run_seq("lw_stall", 0, 6'b100011, 9, 16'b011000111, 64'h043333210, 16'h0);
        run_seq("sw", 0, 6'b101011, 5, 16'b01111, 64'h05210, 16'h0);
        run_seq("beq", 0, 6'b000100, 4, 16'b0111, 64'h0810, 16'h0);
        run_seq("addi", 0, 6'b001000, 5, 16'b01111, 64'h0A910, 16'h0);
        run_seq("j", 0, 6'b000010, 4, 16'b0111, 64'h0B10, 16'h0);
        run_seq("bad_op", 0, 6'b111111, 3, 16'b011, 64'h010, 16'b010);
        run_seq("addi_off", 1, 6'b001000, 3, 16'b011, 64'h010, 16'b010);
        run_seq("j_off", 1, 6'b000010, 3, 16'b011, 64'h010, 16'b010);

        // Reset while stalled in MEMWR
        run_seq("sw_stall", 0, 6'b101011, 4, 16'b0111, 64'h5210, 16'h0);
        rst[0] = 1'b1; mr[0] = 1'b0;
        @(negedge clk);
        check_and_advance();
        chk("reset_memwr_memwrite", 64'(mwr[0]), 64'h0);
        chk("reset_memwr_state", 64'(dbg[0]), 64'h0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check_and_advance();
        chk("after_reset_state", 64'(dbg[0]), 64'h0);
        chk("after_reset_memread", 64'(mrd[0]), 64'h1);
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 99) < 2);
                mr[k]  = ($urandom_range(0, 99) < 70);
                if (m_st[k] == 4'd0) begin
                    case ($urandom_range(0, 6))
                        0: op[k] = 6'b000000;
                        1: op[k] = 6'b100011;
                        2: op[k] = 6'b101011;
                        3: op[k] = 6'b000100;
                        4: op[k] = 6'b001000;
                        5: op[k] = 6'b000010;
                        default: op[k] = 6'($urandom_range(0, 63));
                    endcase
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
